lcv_mul_acc_pipe: RTL and testbench
===================================

LCV_MUL_ACC_PIPE -- requirements
Module: lcv_mul_acc_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, signed operand width.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width; legal range 2*IN_WIDTH .. 64.
REQ-003 SHALL have parameter NUM_CHAN, default 4, number of independent accumulators; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port inp_valid, input, 1, input beat present.
REQ-007 SHALL have port inp_ready, output, 1, input beat accepted when inp_valid && inp_ready.
REQ-008 SHALL have port inp_chan, input, $clog2(NUM_CHAN), target accumulator.
REQ-009 SHALL have ports inp_a and inp_b, input, IN_WIDTH signed each, multiplicands.
REQ-010 SHALL have port inp_clear, input, 1, beat starts a fresh accumulation.
REQ-011 SHALL have port inp_last, input, 1, beat ends accumulation and emits a result.
REQ-012 SHALL have port outp_valid, output, 1, result present.
REQ-013 SHALL have port outp_ready, input, 1, result consumed when outp_valid && outp_ready.
REQ-014 SHALL have port outp_chan, output, $clog2(NUM_CHAN), channel of result.
REQ-015 SHALL have port outp_data, output, ACC_WIDTH signed, accumulated result.
REQ-016 SHALL have port outp_count, output, 16, number of beats in the result; saturates at 0xFFFF.
REQ-017 SHALL have port outp_sat, output, 1, result saturated (see Configuration).

Function
REQ-018 Two stages SHALL be used. S1 registers the product a*b (2*IN_WIDTH signed) with chan, clear and last. S2 accumulates into acc[chan] and cnt[chan], and loads the output register when last=1.
REQ-019 The advance condition SHALL be adv = !outp_valid || outp_ready; inp_ready SHALL equal adv; S1 and S2 SHALL hold all state when adv=0.
REQ-020 On adv with S1 valid, S2 SHALL compute sum = (clear ? 0 : acc[chan]) + sign-extended product. It SHALL write acc[chan] <= sum and cnt[chan] <= (clear ? 1 : cnt[chan]+1, saturating).
REQ-021 If S1 last=1, the same edge SHALL set outp_valid=1 and load outp_data=sum, outp_chan, outp_count. It SHALL then zero acc[chan] and cnt[chan].
REQ-022 Latency SHALL be: a last beat accepted at edge N produces outp_valid=1 after edge N+1. Throughput SHALL be one beat per cycle with outp_ready=1.
REQ-023 The output SHALL be consumed at an edge with adv=1 and no new last in S1; that edge SHALL clear outp_valid. If a new last is present, that edge SHALL load the new result instead (back-to-back results, no bubble).
REQ-024 outp_* SHALL remain stable while outp_valid && !outp_ready.
REQ-025 Back-to-back beats to the same channel SHALL accumulate correctly with no stall; the S2 write precedes the next S2 read.
REQ-026 Beats to different channels SHALL interleave freely; each channel is independent.
REQ-027 Without saturation, arithmetic SHALL wrap modulo 2^ACC_WIDTH.

Reset
REQ-028 While rst=1, the block SHALL asynchronously clear S1 valid, outp_valid, outp_data, outp_chan, outp_count, outp_sat, all acc[] and all cnt[]. inp_ready SHALL read 1 after release.
REQ-029 Reset mid-operation SHALL discard in-flight beats and partial sums; no result SHALL be emitted for them.

Configuration
REQ-030 Macro LCV_MUL_ACC_PIPE_SAT_EN defined: S2 SHALL clamp sum to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. A per-channel sticky sat flag SHALL be set on clamp, cleared by clear/emit, and reported on outp_sat with the result.
REQ-031 Macro undefined: the block SHALL use wrapping arithmetic, and outp_sat SHALL be tied to 0. Port lists SHALL be identical in both builds.

Verification (IN_WIDTH=16, ACC_WIDTH=40, NUM_CHAN=4 unless stated)
REQ-032 Ch0 beats (3,4,clear), (-2,5), (7,7,last) with outp_ready=1 -> one result: chan=0, data=51, count=3, two cycles after the last beat.
REQ-033 Interleave ch1 (10,10,clear),(1,1,last) with ch2 (-5,4,clear),(2,2,last) on alternating cycles -> ch1 data=101 count=2; ch2 data=-16 count=2; outputs in order of last beats.
REQ-034 Result pending with outp_ready=0 for 5 cycles -> inp_ready=0, outp_* stable, no beat dropped; raising outp_ready resumes with the next result correct.
REQ-035 ACC_WIDTH=32, ch0 four beats (-32768,-32768), clear on first, last on fourth -> data=0 and outp_sat=0 without the macro; data=0x7FFFFFFF and outp_sat=1 with the macro.
REQ-036 Assert rst for 1 cycle with S1 holding a ch3 last beat -> no result is emitted. A following ch3 beat (2,3,last) without clear -> data=6, count=1.
REQ-037 Single beat (-4,9) with clear and last both set -> data=-36, count=1.

Source files
------------

// File: rtl/lcv_mul_acc_pipe.sv
// Two-stage multiply-accumulate pipeline with NUM_CHAN independent accumulators and a valid/ready result port.
// Optional build macro LCV_MUL_ACC_PIPE_SAT_EN: clamp sums and report sticky saturation on outp_sat.
module lcv_mul_acc_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 40,
    parameter int NUM_CHAN  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inp_valid,
    output logic                        inp_ready,
    input  logic [$clog2(NUM_CHAN)-1:0] inp_chan,
    input  logic signed [IN_WIDTH-1:0]  inp_a,
    input  logic signed [IN_WIDTH-1:0]  inp_b,
    input  logic                        inp_clear,
    input  logic                        inp_last,
    output logic                        outp_valid,
    input  logic                        outp_ready,
    output logic [$clog2(NUM_CHAN)-1:0] outp_chan,
    output logic signed [ACC_WIDTH-1:0] outp_data,
    output logic [15:0]                 outp_count,
    output logic                        outp_sat
);
    localparam int CW = $clog2(NUM_CHAN);
    localparam int PW = 2 * IN_WIDTH;

    // Handshake: a beat (result) transfers at a rising edge where valid && ready are both high;
    // the whole pipe advances together, so a stalled result freezes S1 and S2 and deasserts inp_ready.
    logic adv;
    assign adv       = !outp_valid || outp_ready;
    assign inp_ready = adv;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    assign a_ext = {{IN_WIDTH{inp_a[IN_WIDTH-1]}}, inp_a};
    assign b_ext = {{IN_WIDTH{inp_b[IN_WIDTH-1]}}, inp_b};
    assign prod  = a_ext * b_ext;

    logic                 s1_valid;
    logic                 s1_clear;
    logic                 s1_last;
    logic [CW-1:0]        s1_chan;
    logic signed [PW-1:0] s1_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_clear <= 1'b0;
            s1_last  <= 1'b0;
            s1_chan  <= '0;
            s1_prod  <= '0;
        end else if (adv) begin
            s1_valid <= inp_valid;
            s1_clear <= inp_clear;
            s1_last  <= inp_last;
            s1_chan  <= inp_chan;
            s1_prod  <= prod;
        end
    end

    logic signed [ACC_WIDTH-1:0] acc [NUM_CHAN];
    logic [15:0]                 cnt [NUM_CHAN];
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [15:0]                 cnt_next;

    always_comb begin
        base     = s1_clear ? '0 : acc[s1_chan];
        cnt_next = 16'd1;
        if (!s1_clear) begin
            cnt_next = (cnt[s1_chan] == 16'hFFFF) ? 16'hFFFF : cnt[s1_chan] + 16'd1;
        end
    end

`ifdef LCV_MUL_ACC_PIPE_SAT_EN
    logic signed [ACC_WIDTH:0] wide;
    logic                      ovf;
    logic                      sat_next;
    logic [NUM_CHAN-1:0]       sat_flag;

    // One guard bit exposes overflow as a disagreement between the top two bits.
    always_comb begin
        wide     = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(s1_prod);
        ovf      = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
        sum      = wide[ACC_WIDTH-1:0];
        if (ovf) begin
            sum = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        sat_next = (s1_clear ? 1'b0 : sat_flag[s1_chan]) | ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= '0;
            outp_sat <= 1'b0;
        end else if (adv && s1_valid) begin
            if (s1_last) begin
                sat_flag[s1_chan] <= 1'b0;
                outp_sat          <= sat_next;
            end else begin
                sat_flag[s1_chan] <= sat_next;
            end
        end
    end
`else
    logic signed [ACC_WIDTH-1:0] prod_ext;

    always_comb begin
        prod_ext = ACC_WIDTH'(s1_prod);
        sum      = base + prod_ext;
    end

    assign outp_sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            outp_valid <= 1'b0;
            outp_chan  <= '0;
            outp_data  <= '0;
            outp_count <= '0;
        end else if (adv) begin
            // Consuming the held result and loading a new one happen on the same edge.
            outp_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    acc[s1_chan] <= '0;
                    cnt[s1_chan] <= '0;
                    outp_chan    <= s1_chan;
                    outp_data    <= sum;
                    outp_count   <= cnt_next;
                end else begin
                    acc[s1_chan] <= sum;
                    cnt[s1_chan] <= cnt_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Self-checking bench for lcv_mul_acc_pipe: vector table, directed corner sequences and
// randomized traffic scored against a per-channel arithmetic model.
module tb_lcv_mul_acc_pipe;
    localparam int AW = 40;

    typedef struct packed {
        logic [1:0]    chan;
        logic [AW-1:0] data;
        logic [15:0]   count;
        logic          sat;
    } res_t;

    typedef struct {
        logic [1:0] chan;
        int         a;
        int         b;
        bit         clear;
        bit         last;
        longint     exp_data;
        int         exp_count;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               inp_valid, inp_ready, inp_clear, inp_last;
    logic [1:0]         inp_chan;
    logic signed [15:0] inp_a, inp_b;
    logic               outp_valid, outp_ready, outp_sat;
    logic [1:0]         outp_chan;
    logic signed [AW-1:0] outp_data;
    logic [15:0]        outp_count;

    logic               x_valid, x_ready, x_clear, x_last;
    logic [1:0]         x_chan;
    logic signed [15:0] x_a, x_b;
    logic               x_outp_valid, x_outp_ready, x_outp_sat;
    logic [1:0]         x_outp_chan;
    logic signed [31:0] x_outp_data;
    logic [15:0]        x_outp_count;

    lcv_mul_acc_pipe dut (
        .clk(clk), .rst(rst),
        .inp_valid(inp_valid), .inp_ready(inp_ready), .inp_chan(inp_chan),
        .inp_a(inp_a), .inp_b(inp_b), .inp_clear(inp_clear), .inp_last(inp_last),
        .outp_valid(outp_valid), .outp_ready(outp_ready), .outp_chan(outp_chan),
        .outp_data(outp_data), .outp_count(outp_count), .outp_sat(outp_sat)
    );

    lcv_mul_acc_pipe #(.IN_WIDTH(16), .ACC_WIDTH(32), .NUM_CHAN(4)) dut32 (
        .clk(clk), .rst(rst),
        .inp_valid(x_valid), .inp_ready(x_ready), .inp_chan(x_chan),
        .inp_a(x_a), .inp_b(x_b), .inp_clear(x_clear), .inp_last(x_last),
        .outp_valid(x_outp_valid), .outp_ready(x_outp_ready), .outp_chan(x_outp_chan),
        .outp_data(x_outp_data), .outp_count(x_outp_count), .outp_sat(x_outp_sat)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_q[$];
    bit   use_model  = 1'b0;
    bit   rand_ready = 1'b0;
    bit   beat_taken = 1'b0;
    bit   prev_stall = 1'b0;
    res_t prev_out;
    logic signed [AW-1:0] m_acc [4];
    int   m_cnt [4];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Reference: clear restarts the channel, every beat adds a*b modulo 2^AW, last emits and restarts.
    task automatic model_beat();
        int     c = int'(inp_chan);
        longint p = longint'(inp_a) * longint'(inp_b);
        res_t   r;
        if (inp_clear) begin
            m_acc[c] = '0;
            m_cnt[c] = 0;
        end
        m_acc[c] = m_acc[c] + AW'(p);
        if (m_cnt[c] < 65535) m_cnt[c]++;
        if (inp_last) begin
            r.chan  = inp_chan;
            r.data  = m_acc[c];
            r.count = 16'(m_cnt[c]);
            r.sat   = 1'b0;
            exp_q.push_back(r);
            m_acc[c] = '0;
            m_cnt[c] = 0;
        end
    endtask

    task automatic monitor();
        res_t got;
        res_t req;
        beat_taken = 1'b0;
        if (rst) begin
            exp_q.delete();
            for (int c = 0; c < 4; c++) begin
                m_acc[c] = '0;
                m_cnt[c] = 0;
            end
            prev_stall = 1'b0;
            return;
        end
        got = res_t'({outp_chan, outp_data, outp_count, outp_sat});
        if (prev_stall) begin
            n_tests++;
            if (got !== prev_out) begin
                n_fail++;
                $display("FAIL stall_stable: got %h required %h", got, prev_out);
            end
        end
        if (outp_valid && outp_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got chan=%0d data=%0d, required no result",
                         got.chan, $signed(got.data));
            end else begin
                req = exp_q.pop_front();
                if (got !== req) begin
                    n_fail++;
                    $display("FAIL result: got chan=%0d data=%0d count=%0d sat=%0d, required chan=%0d data=%0d count=%0d sat=%0d",
                             got.chan, $signed(got.data), got.count, got.sat,
                             req.chan, $signed(req.data), req.count, req.sat);
                end
            end
        end
        if (inp_valid && inp_ready) begin
            beat_taken = 1'b1;
            if (use_model) model_beat();
        end
        prev_stall = outp_valid && !outp_ready;
        prev_out   = got;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_ready) outp_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic send(input logic [1:0] c, input int a, input int b, input bit cl, input bit la);
        int waited = 0;
        inp_chan  = c;
        inp_a     = 16'(a);
        inp_b     = 16'(b);
        inp_clear = cl;
        inp_last  = la;
        inp_valid = 1'b1;
        do begin
            cycle();
            waited++;
        end while (!beat_taken && waited < 100);
        n_tests++;
        if (!beat_taken) begin
            n_fail++;
            $display("FAIL send_timeout: got no accept after %0d cycles, required accept", waited);
        end
        inp_valid = 1'b0;
    endtask

    task automatic expect_res(input logic [1:0] c, input longint d, input int n);
        res_t r;
        r.chan  = c;
        r.data  = AW'(d);
        r.count = 16'(n);
        r.sat   = 1'b0;
        exp_q.push_back(r);
    endtask

    initial begin
        vec_t tbl[11];
        int   waited;

        inp_valid = 0; inp_chan = 0; inp_a = 0; inp_b = 0; inp_clear = 0; inp_last = 0;
        outp_ready = 1;
        x_valid = 0; x_chan = 0; x_a = 0; x_b = 0; x_clear = 0; x_last = 0;
        x_outp_ready = 1;

        tbl[0]  = '{2'd0, 3, 4, 1'b1, 1'b0, 0, 0};
        tbl[1]  = '{2'd0, -2, 5, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{2'd0, 7, 7, 1'b0, 1'b1, 51, 3};
        tbl[3]  = '{2'd1, 10, 10, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{2'd2, -5, 4, 1'b1, 1'b0, 0, 0};
        tbl[5]  = '{2'd1, 1, 1, 1'b0, 1'b1, 101, 2};
        tbl[6]  = '{2'd2, 2, 2, 1'b0, 1'b1, -16, 2};
        tbl[7]  = '{2'd0, -4, 9, 1'b1, 1'b1, -36, 1};
        tbl[8]  = '{2'd3, -32768, -32768, 1'b1, 1'b0, 0, 0};
        tbl[9]  = '{2'd3, -32768, -32768, 1'b0, 1'b1, 64'sd2147483648, 2};
        tbl[10] = '{2'd1, 32767, -32768, 1'b1, 1'b1, -1073709056, 1};

        repeat (3) cycle();
        rst = 1'b0;
        check("reset_outp_valid", outp_valid, 0);
        check("reset_inp_ready", inp_ready, 1);
        check("reset_outp_data", outp_data, 0);
        check("reset_outp_count", outp_count, 0);
        check("reset_outp_sat", outp_sat, 0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].last) expect_res(tbl[i].chan, tbl[i].exp_data, tbl[i].exp_count);
            send(tbl[i].chan, tbl[i].a, tbl[i].b, tbl[i].clear, tbl[i].last);
        end
        // A result leaves channel 2 empty, so a beat without clear starts from zero.
        expect_res(2, 1, 1);
        send(2, 1, 1, 1, 1);
        expect_res(2, 30, 1);
        send(2, 5, 6, 0, 1);
        repeat (4) cycle();

        // Latency: last accepted at edge N, result visible only after edge N+1.
        send(0, 3, 4, 1, 0);
        send(0, -2, 5, 0, 0);
        expect_res(0, 51, 3);
        send(0, 7, 7, 0, 1);
        check("latency_not_early", outp_valid, 0);
        cycle();
        check("latency_valid", outp_valid, 1);
        repeat (3) cycle();

        // Back-pressure: hold outp_ready low with a beat waiting at the input.
        outp_ready = 0;
        expect_res(0, 6, 1);
        send(0, 2, 3, 1, 1);
        expect_res(0, 16, 1);
        send(0, 4, 4, 1, 1);
        expect_res(1, 49, 1);
        inp_chan = 1; inp_a = 7; inp_b = 7; inp_clear = 1; inp_last = 1; inp_valid = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_inp_ready", inp_ready, 0);
            check("stall_outp_valid", outp_valid, 1);
        end
        outp_ready = 1;
        send(1, 7, 7, 1, 1);
        repeat (4) cycle();

        // Reset with a partial sum and a last beat in flight on channel 3.
        send(3, 100, 100, 1, 0);
        send(3, 5, 5, 0, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("post_reset_inp_ready", inp_ready, 1);
        repeat (4) cycle();
        expect_res(3, 6, 1);
        send(3, 2, 3, 0, 1);
        repeat (3) cycle();

        // Overflow behaviour on the 32-bit accumulator instance.
        x_chan = 0; x_a = -32768; x_b = -32768;
        for (int i = 0; i < 4; i++) begin
            x_clear = (i == 0);
            x_last  = (i == 3);
            x_valid = 1'b1;
            @(negedge clk);
            check("acc32_inp_ready", x_ready, 1);
            @(posedge clk);
            #1;
        end
        x_valid = 1'b0;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!x_outp_valid && waited < 10);
        check("acc32_valid", x_outp_valid, 1);
        check("acc32_chan", x_outp_chan, 0);
        check("acc32_count", x_outp_count, 4);
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
        check("acc32_data", x_outp_data, 32'h7FFFFFFF);
        check("acc32_sat", x_outp_sat, 1);
`else
        check("acc32_data", x_outp_data, 0);
        check("acc32_sat", x_outp_sat, 0);
`endif
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure against the reference model.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        use_model  = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                cycle();
            end else begin
                send(2'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end
        rand_ready = 1'b0;
        outp_ready = 1'b1;
        repeat (6) cycle();
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
